card_blit_sequencer: RTL and testbench
======================================

// Module: card_blit_sequencer
// PURPOSE
//  Copies one card bitmap (CARD_W x CARD_H, PIX_W-bit colour codes) from a card
//  sprite memory into the 256x240 frame buffer at pixel origin (cardX, cardY).
//  Sits between game logic (start/done handshake) and the card/frame-buffer RAMs.
//  Streams one pixel per clock; handles the card RAM's 1-cycle registered read
//  latency, transparent-pixel skipping and screen-edge clipping.
// PARAMETERS
//  CARD_W   16      card width in pixels (power of 2)
//  CARD_H   32      card height in pixels; CARD_W*CARD_H = 2**CARD_AW
//  CARD_AW  9       card memory address width
//  SCR_W    256     screen width (fixed 256: fb address = {y,x})
//  SCR_H    240     screen height in lines
//  PIX_W    3       colour-code width
//  TRANSP   3'b000  colour code treated as transparent
// PORTS
//  clock      in   1        system clock, all state on posedge
//  resetN     in   1        asynchronous active-low reset
//  start      in   1        request a blit; sampled only in IDLE
//  cardX      in   8        screen x of card top-left (latched on start)
//  cardY      in   8        screen y of card top-left (latched on start)
//  transpEn   in   1        1 = skip TRANSP pixels (latched on start)
//  busy       out  1        high in FETCH and DRAIN
//  done       out  1        one-cycle pulse after last write slot
//  cardRE     out  1        card memory read enable
//  cardRAddr  out  CARD_AW  card memory read address, row-major (row*CARD_W+col)
//  cardData   in   PIX_W    card memory dataOut (valid the cycle after cardRE)
//  fbWE       out  1        frame-buffer write enable
//  fbWAddr    out  16       frame-buffer address = {y[7:0], x[7:0]}
//  fbData     out  PIX_W    pixel written (= cardData)
// BEHAVIOUR
//  - Reset: state IDLE, counter 0; busy, done, cardRE, fbWE = 0; cardRAddr,
//    fbWAddr, fbData = 0. Reset mid-blit aborts immediately, no done pulse.
//  - FSM: IDLE -start-> FETCH; FETCH -(idx==2**CARD_AW-1)-> DRAIN; DRAIN -> DONE;
//    DONE -> IDLE. start while not IDLE is ignored (not queued).
//  - Start edge: latch cardX/cardY/transpEn, idx <= 0, enter FETCH.
//  - FETCH cycle k (k = 0..511): cardRE=1, cardRAddr=k; idx increments each cycle.
//  - Write pipeline: col/row of read k registered with a valid bit; in cycle k+1
//    (FETCH k+1 or DRAIN) fbData=cardData, fbWAddr={y,x}.
//  - x = cardX+col, y = cardY+row computed 9 bits wide; fbWE=1 only if valid &&
//    x<SCR_W && y<SCR_H && !(transpEn && cardData==TRANSP). No wrap-around:
//    clipped pixels are dropped, never written at a modulo address.
//  - Latency: busy high exactly 2**CARD_AW+1 cycles after start edge; done high
//    for 1 cycle (DONE state), busy=0 then; next start accepted in cycle after done.
//  - fbWAddr/fbData are don't-care when fbWE=0 but must hold reset value 0 in IDLE.
//  - Back-to-back: start held high through DONE starts a new blit from IDLE.
// TESTING
//  1 Reset: resetN=0 with start=1 -> all outputs 0, state IDLE; release -> idle.
//  2 Card RAM = ramp (data=addr%8, 0 -> 1), origin (0,0), transpEn=0 -> 512 writes,
//    write i at fbWAddr={row,col}, data=i%8; busy 513 cycles; done once.
//  3 Same, transpEn=1 -> 448 writes; addresses with i%8==0 never written.
//  4 Origin (250,230) -> only x 250..255, y 230..239 written (6x10 = 60 writes);
//    no write with address >= 0xF000 or x < 250.
//  5 Pulse start at cycle 100 of a blit -> ignored; exactly one done, 512 slots.
//  6 resetN low at FETCH cycle 100 -> outputs 0 same cycle (async), no done;
//    new start after release runs a full clean 513-cycle blit.

Source files
------------

// File: rtl/card_blit_sequencer.sv
// Streams one card bitmap from the card sprite RAM into the 256x240 frame buffer,
// one pixel per clock, with transparent-pixel skipping and screen-edge clipping.
module card_blit_sequencer #(
    parameter int              CARD_W  = 16,
    parameter int              CARD_H  = 32,
    parameter int              CARD_AW = 9,
    parameter int              SCR_W   = 256,
    parameter int              SCR_H   = 240,
    parameter int              PIX_W   = 3,
    parameter logic [PIX_W-1:0] TRANSP = '0
) (
    input  logic               clock,
    input  logic               resetN,
    input  logic               start,
    input  logic [7:0]         cardX,
    input  logic [7:0]         cardY,
    input  logic               transpEn,
    output logic               busy,
    output logic               done,
    output logic               cardRE,
    output logic [CARD_AW-1:0] cardRAddr,
    input  logic [PIX_W-1:0]   cardData,
    output logic               fbWE,
    output logic [15:0]        fbWAddr,
    output logic [PIX_W-1:0]   fbData
);

    localparam int COL_W = $clog2(CARD_W);
    localparam int ROW_W = CARD_AW - COL_W;
    localparam logic [CARD_AW-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t             state;
    logic [CARD_AW-1:0] idx;
    logic [7:0]         org_x, org_y;
    logic               te;

    // Write-slot pipeline: screen coordinates of the read issued last cycle,
    // kept 9 bits wide so overflow past the screen edge clips instead of wrapping.
    logic               wr_vld;
    logic [8:0]         wx, wy;

    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;

    assign col = idx[COL_W-1:0];
    assign row = idx[CARD_AW-1:COL_W];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            idx       <= '0;
            org_x     <= '0;
            org_y     <= '0;
            te        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cardRE    <= 1'b0;
            cardRAddr <= '0;
            wr_vld    <= 1'b0;
            wx        <= '0;
            wy        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done   <= 1'b0;
                    wr_vld <= 1'b0;
                    if (start) begin
                        org_x     <= cardX;
                        org_y     <= cardY;
                        te        <= transpEn;
                        idx       <= '0;
                        busy      <= 1'b1;
                        cardRE    <= 1'b1;
                        cardRAddr <= '0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    idx    <= idx + 1'b1;
                    wr_vld <= 1'b1;
                    wx     <= {1'b0, org_x} + 9'(col);
                    wy     <= {1'b0, org_y} + 9'(row);
                    if (idx == LAST) begin
                        cardRE    <= 1'b0;
                        cardRAddr <= '0;
                        state     <= DRAIN;
                    end else begin
                        cardRAddr <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    wr_vld <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // cardData arrives in the write slot itself, so the write strobe and data
    // are resolved combinationally against the registered slot.
    logic on_screen;
    logic opaque;

    assign on_screen = ({1'b0, wx} < 10'(SCR_W)) && ({1'b0, wy} < 10'(SCR_H));
    assign opaque    = !(te && (cardData == TRANSP));

    assign fbWE    = wr_vld && on_screen && opaque;
    assign fbWAddr = wr_vld ? {wy[7:0], wx[7:0]} : 16'h0000;
    assign fbData  = wr_vld ? cardData : '0;

endmodule

// File: tb/tb_card_blit_sequencer.sv
// Bench for card_blit_sequencer: registered card RAM model, write monitor, and a
// per-blit expected-write list built from pixel coordinates.
module tb_card_blit_sequencer;

    logic        clock = 1'b0;
    logic        resetN;
    logic        start;
    logic [7:0]  cardX, cardY;
    logic        transpEn;
    logic        busy, done, cardRE, fbWE;
    logic [8:0]  cardRAddr;
    logic [2:0]  cardData = 3'd0;
    logic [15:0] fbWAddr;
    logic [2:0]  fbData;

    card_blit_sequencer dut (
        .clock(clock), .resetN(resetN), .start(start),
        .cardX(cardX), .cardY(cardY), .transpEn(transpEn),
        .busy(busy), .done(done), .cardRE(cardRE), .cardRAddr(cardRAddr),
        .cardData(cardData), .fbWE(fbWE), .fbWAddr(fbWAddr), .fbData(fbData)
    );

    always #5 clock = ~clock;

    logic [2:0] mem [512];
    always @(posedge clock) if (cardRE) cardData <= mem[cardRAddr];

    logic [18:0] wq[$];
    logic [18:0] exp_q[$];
    int busy_cnt, done_cnt;
    int checks = 0, passes = 0, fails = 0;

    always @(negedge clock) begin
        if (fbWE) wq.push_back({fbWAddr, fbData});
        if (busy) busy_cnt++;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: every card pixel maps to (x+col, y+row); keep it only if on screen
    // and not a skipped transparent code. Writes appear in card raster order.
    function automatic void build_exp(input int x, input int y, input bit te);
        exp_q.delete();
        for (int i = 0; i < 512; i++) begin
            int px = x + i % 16;
            int py = y + i / 16;
            if (px < 256 && py < 240 && !(te && mem[i] == 3'd0))
                exp_q.push_back({8'(py), 8'(px), mem[i]});
        end
    endfunction

    task automatic start_blit(input int x, input int y, input bit te);
        @(posedge clock);
        wq.delete();
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clock);
        cardX = 8'(x); cardY = 8'(y); transpEn = te; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_blit(input string tag, input int x, input int y, input bit te,
                            input int pulse_at);
        bit seen = 0;
        build_exp(x, y, te);
        start_blit(x, y, te);
        for (int n = 1; n < 1200; n++) begin
            if (n == pulse_at) begin
                start = 1'b1; cardX = 8'(x + 77); cardY = 8'(y + 5); transpEn = !te;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (done_cnt > 0) begin seen = 1; break; end
        end
        start = 1'b0;
        repeat (4) @(negedge clock);
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_busy_cycles"}, busy_cnt, 513);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_write_count"}, wq.size(), exp_q.size());
        begin
            int mism = 0;
            for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
                if (wq[i] !== exp_q[i]) mism++;
            chk({tag, "_write_mismatches"}, mism, 0);
        end
    endtask

    initial begin
        resetN = 1'b0; start = 1'b1; cardX = 8'd0; cardY = 8'd0; transpEn = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 3'(i % 8);

        // 1: reset held with start asserted
        repeat (3) @(negedge clock);
        chk("reset_outputs", {busy, done, cardRE, fbWE, cardRAddr, fbWAddr, fbData}, 0);
        start = 1'b0;
        resetN = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle_after_release", {busy, done, cardRE, fbWE, fbWAddr, fbData}, 0);

        // 2, 3: ramp card at origin, transparency off / on
        run_blit("ramp", 0, 0, 1'b0, -1);
        chk("ramp_512_writes", wq.size(), 512);
        run_blit("ramp_te", 0, 0, 1'b1, -1);
        chk("ramp_te_448_writes", wq.size(), 448);

        // 4: bottom-right corner clipping
        run_blit("clip", 250, 230, 1'b0, -1);
        chk("clip_60_writes", wq.size(), 60);
        begin
            int bad = 0;
            foreach (wq[i]) if (wq[i][18:3] >= 16'hF000 || wq[i][10:3] < 8'd250) bad++;
            chk("clip_bad_addr", bad, 0);
        end
        chk("idle_fb_zero", {fbWAddr, fbData}, 0);

        // 5: start pulse in mid-blit must be ignored
        run_blit("mid_start", 40, 17, 1'b0, 100);

        // 6: async reset during FETCH, then a clean blit
        start_blit(10, 10, 1'b0);
        repeat (100) @(negedge clock);
        #2 resetN = 1'b0;
        #1 chk("async_reset_outputs",
               {busy, done, cardRE, fbWE, cardRAddr, fbWAddr, fbData}, 0);
        @(negedge clock);
        resetN = 1'b1;
        repeat (5) @(negedge clock);
        chk("abort_no_done", done_cnt, 0);
        run_blit("after_abort", 10, 10, 1'b0, -1);

        // randomized cards and origins, biased towards the screen edges
        for (int t = 0; t < 4; t++) begin
            int x, y;
            for (int i = 0; i < 512; i++) mem[i] = 3'($urandom_range(0, 7));
            x = (t % 2) ? $urandom_range(230, 255) : $urandom_range(0, 255);
            y = (t > 1) ? $urandom_range(200, 255) : $urandom_range(0, 255);
            run_blit($sformatf("rand%0d", t), x, y, 1'($urandom_range(0, 1)), -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
